demm_tile_scheduler: RTL and testbench

Sequences a single `demm_calc_kernel` instance over a dense GEMM larger than one kernel tile. It computes Out[M×N] = A[M×K]·B[K×N] with row-major matrices in memory. The block splits the problem into TILE_M×TILE_N×TILE_K tiles and drives the kernel's size, base-address and leading-dimension inputs for each tile. It pulses `calc_begin` once per tile and waits for `calc_end` before advancing. It sits between the host control registers and the kernel; the kernel's `m_axi_A`, `m_axi_B` and `m_axi_Out` ports do not pass through it.

---
 rtl/demm_tile_scheduler_if.sv | 48 ++++
 rtl/demm_tile_scheduler.sv | 277 +++++++++++++++++++++++++++
 tb/tb_demm_tile_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demm_tile_scheduler_if.sv
// Signal bundle between demm_tile_scheduler, its host control registers and
// the kernel's control inputs.
interface demm_tile_scheduler_if #(
    parameter int unsigned DIM_W = 16
);
    logic             start;
    logic             abort;
    logic [DIM_W-1:0] M_total;
    logic [DIM_W-1:0] N_total;
    logic [DIM_W-1:0] K_total;
    logic [31:0]      base_A;
    logic [31:0]      base_B;
    logic [31:0]      base_Out;

    logic [DIM_W-1:0] M_num;
    logic [DIM_W-1:0] N_num;
    logic [DIM_W-1:0] K_num;
    logic [31:0]      addr_A;
    logic [31:0]      addr_B;
    logic [31:0]      addr_Out;
    logic [DIM_W-1:0] ld_A;
    logic [DIM_W-1:0] ld_B;
    logic [DIM_W-1:0] ld_Out;
    logic             accumulate;
    logic             calc_begin;
    logic             calc_end;

    logic             busy;
    logic             done;
    logic             aborted;
    logic [31:0]      tile_cnt;

    // Scheduler side
    modport master (
        input  start, abort, M_total, N_total, K_total, base_A, base_B, base_Out,
        input  calc_end,
        output M_num, N_num, K_num, addr_A, addr_B, addr_Out, ld_A, ld_B, ld_Out,
        output accumulate, calc_begin, busy, done, aborted, tile_cnt
    );

    // Host plus kernel side
    modport slave (
        output start, abort, M_total, N_total, K_total, base_A, base_B, base_Out,
        output calc_end,
        input  M_num, N_num, K_num, addr_A, addr_B, addr_Out, ld_A, ld_B, ld_Out,
        input  accumulate, calc_begin, busy, done, aborted, tile_cnt
    );
endinterface

// File: rtl/demm_tile_scheduler.sv
// Walks a GEMM larger than one kernel tile in TILE_M x TILE_N x TILE_K steps,
// driving the kernel's per-tile sizes, byte addresses and leading dimensions.
module demm_tile_scheduler #(
    parameter int unsigned TILE_M     = 512,
    parameter int unsigned TILE_N     = 32,
    parameter int unsigned TILE_K     = 32,
    parameter int unsigned ELEM_BYTES = 4,
    parameter int unsigned DIM_W      = 16
) (
    input logic                   clk,
    input logic                   rstn,
    demm_tile_scheduler_if.master bus
);

    localparam int unsigned AW = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [DIM_W-1:0] TM = DIM_W'(TILE_M);
    localparam logic [DIM_W-1:0] TN = DIM_W'(TILE_N);
    localparam logic [DIM_W-1:0] TK = DIM_W'(TILE_K);
    localparam logic [AW-1:0] M_STEP_B = AW'(TILE_M * ELEM_BYTES);
    localparam logic [AW-1:0] N_STEP_B = AW'(TILE_N * ELEM_BYTES);
    localparam logic [AW-1:0] K_STEP_B = AW'(TILE_K * ELEM_BYTES);

    logic [2:0]       state, state_nxt;
    logic [DIM_W-1:0] m_rem, m_rem_nxt, n_rem, n_rem_nxt, k_rem, k_rem_nxt;
    logic [DIM_W-1:0] n_tot, n_tot_nxt, k_tot, k_tot_nxt;
    logic [AW-1:0]    base_b, base_b_nxt;
    logic [AW-1:0]    a_row, a_row_nxt, b_row, b_row_nxt, o_row, o_row_nxt;
    logic [AW-1:0]    k_byte, k_byte_nxt, n_byte, n_byte_nxt;
    logic [AW-1:0]    step_a, step_a_nxt, step_b, step_b_nxt, step_o, step_o_nxt;
    logic             ki_nz, ki_nz_nxt;
    logic             abort_flag, abort_flag_nxt;
    logic             empty, empty_nxt;

    logic [DIM_W-1:0] m_num, m_num_nxt, n_num, n_num_nxt, k_num, k_num_nxt;
    logic [AW-1:0]    addr_a, addr_a_nxt, addr_b, addr_b_nxt, addr_out, addr_out_nxt;
    logic [DIM_W-1:0] ld_a, ld_a_nxt, ld_b, ld_b_nxt, ld_out, ld_out_nxt;
    logic             accumulate, accumulate_nxt;
    logic             calc_begin, calc_begin_nxt;
    logic             busy, busy_nxt, done, done_nxt, aborted, aborted_nxt;
    logic [31:0]      tile_cnt, tile_cnt_nxt;

    logic m_last, n_last, k_last, last_tile, zero_dim;

    function automatic logic [DIM_W-1:0] clip(input logic [DIM_W-1:0] rem,
                                              input logic [DIM_W-1:0] tile);
        return (rem < tile) ? rem : tile;
    endfunction

    // Remaining extent fits in one tile => this index is at its last value
    assign m_last    = (m_rem <= TM);
    assign n_last    = (n_rem <= TN);
    assign k_last    = (k_rem <= TK);
    assign last_tile = m_last && n_last && k_last;
    assign zero_dim  = (bus.M_total == '0) || (bus.N_total == '0) || (bus.K_total == '0);

    always_comb begin
        state_nxt      = state;
        m_rem_nxt      = m_rem;
        n_rem_nxt      = n_rem;
        k_rem_nxt      = k_rem;
        n_tot_nxt      = n_tot;
        k_tot_nxt      = k_tot;
        base_b_nxt     = base_b;
        a_row_nxt      = a_row;
        b_row_nxt      = b_row;
        o_row_nxt      = o_row;
        k_byte_nxt     = k_byte;
        n_byte_nxt     = n_byte;
        step_a_nxt     = step_a;
        step_b_nxt     = step_b;
        step_o_nxt     = step_o;
        ki_nz_nxt      = ki_nz;
        abort_flag_nxt = abort_flag;
        empty_nxt      = empty;
        m_num_nxt      = m_num;
        n_num_nxt      = n_num;
        k_num_nxt      = k_num;
        addr_a_nxt     = addr_a;
        addr_b_nxt     = addr_b;
        addr_out_nxt   = addr_out;
        ld_a_nxt       = ld_a;
        ld_b_nxt       = ld_b;
        ld_out_nxt     = ld_out;
        accumulate_nxt = accumulate;
        calc_begin_nxt = 1'b0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        aborted_nxt    = aborted;
        tile_cnt_nxt   = tile_cnt;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    m_rem_nxt      = bus.M_total;
                    n_rem_nxt      = bus.N_total;
                    k_rem_nxt      = bus.K_total;
                    n_tot_nxt      = bus.N_total;
                    k_tot_nxt      = bus.K_total;
                    base_b_nxt     = bus.base_B;
                    a_row_nxt      = bus.base_A;
                    b_row_nxt      = bus.base_B;
                    o_row_nxt      = bus.base_Out;
                    k_byte_nxt     = '0;
                    n_byte_nxt     = '0;
                    // Row strides in bytes: the only multiplies in the block
                    step_a_nxt     = M_STEP_B * AW'(bus.K_total);
                    step_b_nxt     = K_STEP_B * AW'(bus.N_total);
                    step_o_nxt     = M_STEP_B * AW'(bus.N_total);
                    ki_nz_nxt      = 1'b0;
                    abort_flag_nxt = 1'b0;
                    aborted_nxt    = 1'b0;
                    tile_cnt_nxt   = '0;
                    empty_nxt      = zero_dim;
                    // An empty problem passes through NEXT so done keeps the usual two-cycle offset
                    state_nxt      = zero_dim ? S_NEXT : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.calc_end) begin
                    tile_cnt_nxt = tile_cnt + 32'd1;
                    state_nxt    = S_NEXT;
                end
            end
            S_NEXT: begin
                if (empty || abort_flag || bus.abort || last_tile) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_ISSUE;
                    // Loop order mi (outer), ni, ki (inner)
                    if (!k_last) begin
                        k_rem_nxt  = k_rem - TK;
                        k_byte_nxt = k_byte + K_STEP_B;
                        b_row_nxt  = b_row + step_b;
                        ki_nz_nxt  = 1'b1;
                    end else begin
                        k_rem_nxt  = k_tot;
                        k_byte_nxt = '0;
                        b_row_nxt  = base_b;
                        ki_nz_nxt  = 1'b0;
                        if (!n_last) begin
                            n_rem_nxt  = n_rem - TN;
                            n_byte_nxt = n_byte + N_STEP_B;
                        end else begin
                            n_rem_nxt  = n_tot;
                            n_byte_nxt = '0;
                            m_rem_nxt  = m_rem - TM;
                            a_row_nxt  = a_row + step_a;
                            o_row_nxt  = o_row + step_o;
                        end
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if ((state == S_ISSUE || state == S_WAIT || state == S_NEXT) && bus.abort)
            abort_flag_nxt = 1'b1;

        // Tile outputs are reloaded only on entry to ISSUE
        if (state_nxt == S_ISSUE) begin
            m_num_nxt      = clip(m_rem_nxt, TM);
            n_num_nxt      = clip(n_rem_nxt, TN);
            k_num_nxt      = clip(k_rem_nxt, TK);
            addr_a_nxt     = a_row_nxt + k_byte_nxt;
            addr_b_nxt     = b_row_nxt + n_byte_nxt;
            addr_out_nxt   = o_row_nxt + n_byte_nxt;
            ld_a_nxt       = k_tot_nxt;
            ld_b_nxt       = n_tot_nxt;
            ld_out_nxt     = n_tot_nxt;
            accumulate_nxt = ki_nz_nxt;
        end

        calc_begin_nxt = (state_nxt == S_ISSUE);
        busy_nxt       = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT) || (state_nxt == S_NEXT);
        done_nxt       = (state_nxt == S_FIN);
        if (state_nxt == S_FIN)
            aborted_nxt = abort_flag_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            m_rem      <= '0;
            n_rem      <= '0;
            k_rem      <= '0;
            n_tot      <= '0;
            k_tot      <= '0;
            base_b     <= '0;
            a_row      <= '0;
            b_row      <= '0;
            o_row      <= '0;
            k_byte     <= '0;
            n_byte     <= '0;
            step_a     <= '0;
            step_b     <= '0;
            step_o     <= '0;
            ki_nz      <= 1'b0;
            abort_flag <= 1'b0;
            empty      <= 1'b0;
            m_num      <= '0;
            n_num      <= '0;
            k_num      <= '0;
            addr_a     <= '0;
            addr_b     <= '0;
            addr_out   <= '0;
            ld_a       <= '0;
            ld_b       <= '0;
            ld_out     <= '0;
            accumulate <= 1'b0;
            calc_begin <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            tile_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            m_rem      <= m_rem_nxt;
            n_rem      <= n_rem_nxt;
            k_rem      <= k_rem_nxt;
            n_tot      <= n_tot_nxt;
            k_tot      <= k_tot_nxt;
            base_b     <= base_b_nxt;
            a_row      <= a_row_nxt;
            b_row      <= b_row_nxt;
            o_row      <= o_row_nxt;
            k_byte     <= k_byte_nxt;
            n_byte     <= n_byte_nxt;
            step_a     <= step_a_nxt;
            step_b     <= step_b_nxt;
            step_o     <= step_o_nxt;
            ki_nz      <= ki_nz_nxt;
            abort_flag <= abort_flag_nxt;
            empty      <= empty_nxt;
            m_num      <= m_num_nxt;
            n_num      <= n_num_nxt;
            k_num      <= k_num_nxt;
            addr_a     <= addr_a_nxt;
            addr_b     <= addr_b_nxt;
            addr_out   <= addr_out_nxt;
            ld_a       <= ld_a_nxt;
            ld_b       <= ld_b_nxt;
            ld_out     <= ld_out_nxt;
            accumulate <= accumulate_nxt;
            calc_begin <= calc_begin_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
            tile_cnt   <= tile_cnt_nxt;
        end
    end

    assign bus.M_num      = m_num;
    assign bus.N_num      = n_num;
    assign bus.K_num      = k_num;
    assign bus.addr_A     = addr_a;
    assign bus.addr_B     = addr_b;
    assign bus.addr_Out   = addr_out;
    assign bus.ld_A       = ld_a;
    assign bus.ld_B       = ld_b;
    assign bus.ld_Out     = ld_out;
    assign bus.accumulate = accumulate;
    assign bus.calc_begin = calc_begin;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.aborted    = aborted;
    assign bus.tile_cnt   = tile_cnt;

endmodule

// File: tb/tb_demm_tile_scheduler.sv
// Scoreboard bench for demm_tile_scheduler: expected tiles are queued at start
// and compared each time the scheduler pulses calc_begin.
module tb_demm_tile_scheduler;

    localparam int unsigned DIM_W = 16;
    localparam int unsigned TM = 512;
    localparam int unsigned TN = 32;
    localparam int unsigned TK = 32;
    localparam int unsigned EB = 4;

    typedef struct {
        logic [15:0] m, n, k;
        logic [31:0] a, b, o;
        logic [15:0] lda, ldb;
        logic        acc;
    } tile_t;

    tile_t exp_q[$];
    logic  clk = 1'b0;
    logic  rstn;
    int    pass_cnt = 0;
    int    chk_cnt = 0;

    demm_tile_scheduler_if #(.DIM_W(DIM_W)) bif ();

    demm_tile_scheduler #(
        .TILE_M(TM), .TILE_N(TN), .TILE_K(TK), .ELEM_BYTES(EB), .DIM_W(DIM_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [228:0] all_outs();
        return {bif.M_num, bif.N_num, bif.K_num, bif.addr_A, bif.addr_B, bif.addr_Out,
                bif.ld_A, bif.ld_B, bif.ld_Out, bif.tile_cnt,
                bif.accumulate, bif.calc_begin, bif.busy, bif.done, bif.aborted};
    endfunction

    // Queue the expected tile sequence, then pulse start into the scheduler
    task automatic do_start(input int unsigned m, input int unsigned n, input int unsigned k,
                            input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bo);
        tile_t t;
        if (m != 0 && n != 0 && k != 0)
            for (int unsigned m0 = 0; m0 < m; m0 += TM)
                for (int unsigned n0 = 0; n0 < n; n0 += TN)
                    for (int unsigned k0 = 0; k0 < k; k0 += TK) begin
                        t.m   = 16'((m - m0 < TM) ? m - m0 : TM);
                        t.n   = 16'((n - n0 < TN) ? n - n0 : TN);
                        t.k   = 16'((k - k0 < TK) ? k - k0 : TK);
                        t.a   = ba + 32'((m0 * k + k0) * EB);
                        t.b   = bb + 32'((k0 * n + n0) * EB);
                        t.o   = bo + 32'((m0 * n + n0) * EB);
                        t.lda = 16'(k);
                        t.ldb = 16'(n);
                        t.acc = (k0 != 0);
                        exp_q.push_back(t);
                    end
        @(negedge clk);
        bif.M_total  = 16'(m);
        bif.N_total  = 16'(n);
        bif.K_total  = 16'(k);
        bif.base_A   = ba;
        bif.base_B   = bb;
        bif.base_Out = bo;
        bif.start    = 1'b1;
    endtask

    // Kernel model plus scoreboard: answers each calc_begin after lat cycles
    task automatic drive_run(input int lat, input int restart_at, input int abort_at,
                             input bit stray, output int begins);
        tile_t e;
        int    pend = -1;
        int    since_end = -1;
        bit    fin = 1'b0;
        bit    abort_next = 1'b0;
        begins = 0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge clk);
            bif.start    = 1'b0;
            bif.abort    = 1'b0;
            bif.calc_end = 1'b0;
            if (abort_next) begin
                bif.abort  = 1'b1;
                abort_next = 1'b0;
            end
            if (since_end >= 0) since_end++;
            if (c == 0) begin
                chk_cnt++;
                if (bif.busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", bif.busy);
                else pass_cnt++;
            end
            if (pend == 0) begin
                bif.calc_end = 1'b1;
                since_end    = 0;
                pend         = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (bif.calc_begin === 1'b1) begin
                begins++;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL tile%0d: unexpected calc_begin, none queued", begins);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.M_num, bif.N_num, bif.K_num, bif.addr_A, bif.addr_B, bif.addr_Out,
                         bif.ld_A, bif.ld_B, bif.ld_Out, bif.accumulate} !==
                        {e.m, e.n, e.k, e.a, e.b, e.o, e.lda, e.ldb, e.ldb, e.acc})
                        $display("FAIL tile%0d: got M=%0d N=%0d K=%0d A=%h B=%h O=%h ld=%0d/%0d/%0d acc=%b want M=%0d N=%0d K=%0d A=%h B=%h O=%h ld=%0d/%0d/%0d acc=%b",
                                 begins, bif.M_num, bif.N_num, bif.K_num, bif.addr_A, bif.addr_B,
                                 bif.addr_Out, bif.ld_A, bif.ld_B, bif.ld_Out, bif.accumulate,
                                 e.m, e.n, e.k, e.a, e.b, e.o, e.lda, e.ldb, e.ldb, e.acc);
                    else pass_cnt++;
                end
                if (since_end >= 0) begin
                    chk_cnt++;
                    if (since_end !== 2) $display("FAIL issue_gap: got %0d cycles want 2", since_end);
                    else pass_cnt++;
                end else begin
                    chk_cnt++;
                    if (c !== 0) $display("FAIL first_issue: got cycle %0d want 0", c);
                    else pass_cnt++;
                end
                pend = lat;
                if (stray) bif.calc_end = 1'b1;
                if (begins == abort_at) abort_next = 1'b1;
                if (begins == restart_at) bif.start = 1'b1;
            end
            if (bif.done === 1'b1) begin
                fin = 1'b1;
                chk_cnt++;
                if (begins > 0 && since_end !== 2)
                    $display("FAIL done_gap: got %0d cycles after calc_end want 2", since_end);
                else if (begins == 0 && c !== 1)
                    $display("FAIL done_gap: got cycle %0d after start want 1", c);
                else pass_cnt++;
                chk_cnt++;
                if (bif.busy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", bif.busy);
                else pass_cnt++;
            end
        end
        bif.calc_end = 1'b0;
        bif.abort    = 1'b0;
        if (!fin) begin
            chk_cnt++;
            $display("FAIL run_timeout: got no done want done");
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outs());
        else pass_cnt++;
        rstn = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (all_outs() !== '0) $display("FAIL idle_outputs: got %h want 0", all_outs());
        else pass_cnt++;
    endtask

    task automatic test_run(input string name, input int unsigned m, input int unsigned n,
                            input int unsigned k, input int lat, input bit stray, input int want);
        int begins;
        do_start(m, n, k, 32'h0000_0000, 32'h0001_0000, 32'h0002_0000);
        drive_run(lat, -1, -1, stray, begins);
        chk_cnt++;
        if (begins !== want || bif.tile_cnt !== 32'(want))
            $display("FAIL %s_count: got begins=%0d tile_cnt=%0d want %0d", name, begins, bif.tile_cnt, want);
        else pass_cnt++;
        chk_cnt++;
        if (bif.aborted !== 1'b0 || exp_q.size() != 0)
            $display("FAIL %s_end: got aborted=%b left=%0d want 0/0", name, bif.aborted, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_abort();
        int begins;
        do_start(1024, 64, 64, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000);
        @(posedge clk);
        #1;
        // A relatch from the mid-run start would pick these up
        bif.M_total  = 16'd32;
        bif.N_total  = 16'd32;
        bif.K_total  = 16'd32;
        bif.base_A   = 32'hdead_0000;
        bif.base_B   = 32'hbeef_0000;
        bif.base_Out = 32'hcafe_0000;
        drive_run(2, 2, 3, 1'b0, begins);
        chk_cnt++;
        if (begins !== 3 || bif.tile_cnt !== 32'd3)
            $display("FAIL abort_count: got begins=%0d tile_cnt=%0d want 3", begins, bif.tile_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (bif.aborted !== 1'b1) $display("FAIL abort_flag: got %b want 1", bif.aborted);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bif.aborted !== 1'b1 || bif.busy !== 1'b0 || exp_q.size() != 5)
            $display("FAIL abort_hold: got aborted=%b busy=%b left=%0d want 1/0/5",
                     bif.aborted, bif.busy, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        tile_t e;
        bit    seen = 1'b0;
        bit    bad_done = 1'b0;
        int    begins;
        do_start(1024, 64, 64, 32'h0000_4000, 32'h0000_8000, 32'h0000_c000);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            bif.start = 1'b0;
            if (bif.calc_begin === 1'b1) seen = 1'b1;
        end
        chk_cnt++;
        if (!seen || exp_q.size() == 0) begin
            $display("FAIL midrst_issue: got no calc_begin want one");
        end else begin
            e = exp_q.pop_front();
            if (bif.addr_A !== e.a || bif.M_num !== e.m)
                $display("FAIL midrst_issue: got A=%h M=%0d want A=%h M=%0d", bif.addr_A, bif.M_num, e.a, e.m);
            else pass_cnt++;
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (all_outs() !== '0) $display("FAIL midrst_outputs: got %h want 0", all_outs());
        else pass_cnt++;
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bif.done !== 1'b0 || bif.busy !== 1'b0) bad_done = 1'b1;
        end
        chk_cnt++;
        if (bad_done) $display("FAIL midrst_quiet: got done/busy after reset want none");
        else pass_cnt++;
        exp_q.delete();
        do_start(512, 32, 32, 32'h0000_4000, 32'h0000_8000, 32'h0000_c000);
        drive_run(1, -1, -1, 1'b0, begins);
        chk_cnt++;
        if (begins !== 1 || bif.tile_cnt !== 32'd1 || exp_q.size() != 0)
            $display("FAIL midrst_rerun: got begins=%0d tile_cnt=%0d want 1", begins, bif.tile_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rstn         = 1'b0;
        bif.start    = 1'b0;
        bif.abort    = 1'b0;
        bif.calc_end = 1'b0;
        bif.M_total  = '0;
        bif.N_total  = '0;
        bif.K_total  = '0;
        bif.base_A   = '0;
        bif.base_B   = '0;
        bif.base_Out = '0;

        test_reset();
        test_run("single", 512, 32, 32, 3, 1'b0, 1);
        test_run("multi", 1024, 64, 64, 1, 1'b1, 8);
        test_run("edge", 600, 40, 50, 0, 1'b0, 8);
        test_run("zero_k", 600, 40, 0, 1, 1'b0, 0);
        test_run("zero_m", 0, 32, 32, 1, 1'b0, 0);
        test_abort();
        test_run("back_to_back", 512, 64, 32, 2, 1'b0, 2);
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
